adder_share_arbiter: RTL and testbench

- Time-shares one 4-bit combinational adder (Y = A + B, modulo 16, no carry out) among NUM_REQ requesters.
- Round-robin arbitration; accepted operands are latched, driven into the adder, and the result is returned with the winner's ID.
- Sits between the requester blocks and a single external 4-bit adder instance, which it drives through dedicated operand/result ports.

---
 rtl/adder_share_arbiter_if.sv | 33 +++
 rtl/adder_share_arbiter.sv | 131 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_if.sv
// Bundles the requester handshake, the shared-adder operand/result path and the
// result/status signals of adder_share_arbiter.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = 2,
    parameter int CNTW    = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] a_in;
    logic [NUM_REQ*WIDTH-1:0] b_in;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_y;
    logic                     res_valid;
    logic [IDW-1:0]           res_id;
    logic [WIDTH-1:0]         res_data;
    logic                     busy;
    logic [CNTW-1:0]          op_count;

    // Requesters plus the external adder: drive requests/sum, observe the rest.
    modport master (
        output req, a_in, b_in, add_y,
        input  gnt, add_a, add_b, res_valid, res_id, res_data, busy, op_count
    );

    // The arbiter itself.
    modport slave (
        input  req, a_in, b_in, add_y,
        output gnt, add_a, add_b, res_valid, res_id, res_data, busy, op_count
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing of one external combinational adder among NUM_REQ
// requesters: accept (IDLE) -> drive adder (EXEC) -> present result (RESP).
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int IDW     = 2,
    parameter int CNTW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               res_valid_q, res_valid_d;
    logic [IDW-1:0]     res_id_q, res_id_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic [CNTW-1:0]    op_count_q, op_count_d;

    logic               found;
    logic [IDW-1:0]     win;

    // Next index after k, wrapping at NUM_REQ (not at 2^IDW).
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] k);
        if (int'(k) == NUM_REQ - 1)
            next_idx = '0;
        else
            next_idx = k + IDW'(1);
    endfunction

    // Rotating priority scan starting at ptr_q: first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && bus.req[(int'(ptr_q) + off) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    op_a_d  = bus.a_in[int'(win)*WIDTH +: WIDTH];
                    op_b_d  = bus.b_in[int'(win)*WIDTH +: WIDTH];
                    id_d    = win;
                    gnt_d   = NUM_REQ'(1) << win;
                    ptr_d   = next_idx(win);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = bus.add_y;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                op_count_d = op_count_q + CNTW'(1);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the datapath registers, clears on reset so an
    // aborted operation leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
            op_count_q  <= op_count_d;
        end
    end

    // Adder operands come straight from registers, so they are glitch-free.
    assign bus.gnt       = gnt_q;
    assign bus.add_a     = op_a_q;
    assign bus.add_b     = op_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with a behavioural
// 4-bit adder closing the add_a/add_b -> add_y loop.
module tb_adder_share_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    adder_share_arbiter_if #(.NUM_REQ(4), .WIDTH(4), .IDW(2), .CNTW(8)) ifc ();

    adder_share_arbiter #(.NUM_REQ(4), .WIDTH(4), .IDW(2), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    assign ifc.add_y = ifc.add_a + ifc.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        ifc.a_in[i*4 +: 4] = a;
        ifc.b_in[i*4 +: 4] = b;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ifc.req = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ifc.a_in = '1;
        ifc.b_in = '1;
        do_reset();
        n_checks++;
        if (ifc.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", ifc.gnt); end
        n_checks++;
        if (ifc.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", ifc.res_valid); end
        n_checks++;
        if (ifc.res_id !== 2'd0 || ifc.res_data !== 4'd0) begin
            n_fail++; $display("FAIL reset_res: id %0d data %0d want 0 0", ifc.res_id, ifc.res_data);
        end
        n_checks++;
        if (ifc.add_a !== 4'd0 || ifc.add_b !== 4'd0) begin
            n_fail++; $display("FAIL reset_add_ops: a %0d b %0d want 0 0", ifc.add_a, ifc.add_b);
        end
        n_checks++;
        if (ifc.op_count !== 8'd0 || ifc.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt_busy: cnt %0d busy %b want 0 0", ifc.op_count, ifc.busy);
        end
    endtask

    task automatic test_single();
        ifc.a_in = '0;
        ifc.b_in = '0;
        set_op(0, 4'd3, 4'd4);
        ifc.req = 4'b0001;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b0001 || ifc.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt: gnt %b busy %b want 0001 1", ifc.gnt, ifc.busy);
        end
        n_checks++;
        if (ifc.add_a !== 4'd3 || ifc.add_b !== 4'd4) begin
            n_fail++; $display("FAIL single_add_ops: a %0d b %0d want 3 4", ifc.add_a, ifc.add_b);
        end
        ifc.req = 4'b0000;
        cyc();
        n_checks++;
        if (ifc.res_valid !== 1'b1 || ifc.res_id !== 2'd0 || ifc.res_data !== 4'd7 || ifc.gnt !== 4'b0000 || ifc.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_res: v %b id %0d data %0d gnt %b busy %b want 1 0 7 0000 1",
                               ifc.res_valid, ifc.res_id, ifc.res_data, ifc.gnt, ifc.busy);
        end
        cyc();
        n_checks++;
        if (ifc.res_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.op_count !== 8'd1 || ifc.res_data !== 4'd7) begin
            n_fail++; $display("FAIL single_done: v %b busy %b cnt %0d data %0d want 0 0 1 7",
                               ifc.res_valid, ifc.busy, ifc.op_count, ifc.res_data);
        end
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b0000 || ifc.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: gnt %b busy %b want 0000 0", ifc.gnt, ifc.busy);
        end
    endtask

    task automatic test_all_rr();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_sum [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd2};
        do_reset();
        set_op(0, 4'd1, 4'd1);
        set_op(1, 4'd2, 4'd2);
        set_op(2, 4'd3, 4'd3);
        set_op(3, 4'd4, 4'd4);
        ifc.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            n_checks++;
            if (ifc.gnt !== exp_gnt[k]) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, ifc.gnt, exp_gnt[k]);
            end
            cyc();
            n_checks++;
            if (ifc.res_valid !== 1'b1 || ifc.res_id !== exp_id[k] || ifc.res_data !== exp_sum[k]) begin
                n_fail++; $display("FAIL rr_res[%0d]: v %b id %0d data %0d want 1 %0d %0d",
                                   k, ifc.res_valid, ifc.res_id, ifc.res_data, exp_id[k], exp_sum[k]);
            end
            cyc();
            n_checks++;
            if (ifc.busy !== 1'b0 || ifc.op_count !== 8'(k + 1)) begin
                n_fail++; $display("FAIL rr_cnt[%0d]: busy %b cnt %0d want 0 %0d", k, ifc.busy, ifc.op_count, k + 1);
            end
        end
        ifc.req = 4'b0000;
    endtask

    task automatic test_overflow();
        logic [3:0] av [2] = '{4'd9, 4'd15};
        logic [3:0] bv [2] = '{4'd8, 4'd15};
        logic [3:0] ev [2] = '{4'd1, 4'd14};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_op(2, av[k], bv[k]);
            ifc.req = 4'b0100;
            cyc();
            n_checks++;
            if (ifc.gnt !== 4'b0100) begin
                n_fail++; $display("FAIL ovf_gnt[%0d]: got %b want 0100", k, ifc.gnt);
            end
            ifc.req = 4'b0000;
            cyc();
            n_checks++;
            if (ifc.res_valid !== 1'b1 || ifc.res_id !== 2'd2 || ifc.res_data !== ev[k]) begin
                n_fail++; $display("FAIL ovf_res[%0d]: v %b id %0d data %0d want 1 2 %0d",
                                   k, ifc.res_valid, ifc.res_id, ifc.res_data, ev[k]);
            end
            cyc();
        end
    endtask

    // Entered with ptr = 3 (last grant went to requester 2).
    task automatic test_rr_pointer();
        set_op(1, 4'd7, 4'd7);
        set_op(3, 4'd5, 4'd6);
        ifc.req = 4'b1010;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b1000) begin n_fail++; $display("FAIL ptr_first_gnt: got %b want 1000", ifc.gnt); end
        ifc.req = 4'b0010;
        cyc();
        n_checks++;
        if (ifc.res_id !== 2'd3 || ifc.res_data !== 4'd11) begin
            n_fail++; $display("FAIL ptr_first_res: id %0d data %0d want 3 11", ifc.res_id, ifc.res_data);
        end
        cyc();
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b0010) begin n_fail++; $display("FAIL ptr_second_gnt: got %b want 0010", ifc.gnt); end
        ifc.req = 4'b0000;
        cyc();
        n_checks++;
        if (ifc.res_id !== 2'd1 || ifc.res_data !== 4'd14) begin
            n_fail++; $display("FAIL ptr_second_res: id %0d data %0d want 1 14", ifc.res_id, ifc.res_data);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        set_op(3, 4'd2, 4'd3);
        ifc.req = 4'b1000;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_gnt: got %b want 1000", ifc.gnt); end
        rst_n   = 1'b0;
        ifc.req = 4'b0000;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b0000 || ifc.res_valid !== 1'b0 || ifc.op_count !== 8'd0 || ifc.busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_state: gnt %b v %b cnt %0d busy %b want 0000 0 0 0",
                               ifc.gnt, ifc.res_valid, ifc.op_count, ifc.busy);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++;
            if (ifc.res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid[%0d]: got %b want 0", k, ifc.res_valid); end
        end
        ifc.req = 4'b1000;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_regnt: got %b want 1000", ifc.gnt); end
        ifc.req = 4'b0000;
        cyc();
        n_checks++;
        if (ifc.res_valid !== 1'b1 || ifc.res_id !== 2'd3 || ifc.res_data !== 4'd5) begin
            n_fail++; $display("FAIL abort_reres: v %b id %0d data %0d want 1 3 5", ifc.res_valid, ifc.res_id, ifc.res_data);
        end
        cyc();
        n_checks++;
        if (ifc.op_count !== 8'd1) begin n_fail++; $display("FAIL abort_cnt: got %0d want 1", ifc.op_count); end
    endtask

    // Entered with ptr = 0.
    task automatic test_operand_change();
        set_op(1, 4'd6, 4'd5);
        ifc.req = 4'b0010;
        cyc();
        n_checks++;
        if (ifc.gnt !== 4'b0010) begin n_fail++; $display("FAIL opchg_gnt: got %b want 0010", ifc.gnt); end
        set_op(1, 4'd1, 4'd0);
        ifc.req = 4'b0000;
        cyc();
        n_checks++;
        if (ifc.res_id !== 2'd1 || ifc.res_data !== 4'd11) begin
            n_fail++; $display("FAIL opchg_res: id %0d data %0d want 1 11", ifc.res_id, ifc.res_data);
        end
        cyc();
        n_checks++;
        if (ifc.add_a !== 4'd6 || ifc.add_b !== 4'd5) begin
            n_fail++; $display("FAIL opchg_hold_ops: a %0d b %0d want 6 5", ifc.add_a, ifc.add_b);
        end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        set_op(0, 4'd1, 4'd2);
        ifc.req = 4'b0001;
        for (int i = 1; i <= 256; i++) begin
            cyc();
            cyc();
            cyc();
            if (i == 1) begin
                n_checks++;
                if (ifc.op_count !== 8'd1 || ifc.res_data !== 4'd3) begin
                    n_fail++; $display("FAIL b2b_first: cnt %0d data %0d want 1 3", ifc.op_count, ifc.res_data);
                end
            end
            if (i == 255) begin
                n_checks++;
                if (ifc.op_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", ifc.op_count); end
            end
        end
        n_checks++;
        if (ifc.op_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", ifc.op_count); end
        ifc.req = 4'b0000;
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ifc.req  = '0;
        ifc.a_in = '0;
        ifc.b_in = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_overflow();
        test_rr_pointer();
        test_reset_mid();
        test_operand_change();
        test_back_to_back_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
